// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encoding is 3 bits wide, so the three unused codes must recover to IDLE.
package button_debouncer_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  // Defaults assume a 100 MHz clk.
  localparam int DEF_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 50_000_000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 10_000_000;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle.
// The debouncer drives the strobes through the master modport; the display counter listens as slave.
interface button_debouncer_if;
  logic button_in;
  logic button_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic step_pulse;

  modport master (
    input  button_in,
    output button_level, press_pulse, release_pulse, repeat_pulse, step_pulse
  );

  modport slave (
    output button_in,
    input  button_level, press_pulse, release_pulse, repeat_pulse, step_pulse
  );
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// RESET_VAL lets the same block serve reset, switch and button inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one push-button and produces press, release and auto-repeat strobes.
// A single counter is shared by all timed states, because only one interval is ever being measured.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int ACTIVE_LOW          = 0
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.master bus
);

  localparam int MAX_CYCLES = maxOf3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // The delay measured in PRESSED excludes the debounce already spent in PRESS_WAIT.
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYCLES - DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYCLES - 1);

  logic          pinPressed;
  logic          syncPressed;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          step_q;

  assign pinPressed = bus.button_in ^ (ACTIVE_LOW != 0);

  sync_2ff #(.RESET_VAL(1'b0)) uSync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pinPressed),
    .q_o   (syncPressed)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (syncPressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!syncPressed) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED, REPEAT: begin
        if (!syncPressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == PRESSED) ? DELAY_LAST : RATE_LAST)) begin
          state_d  = REPEAT;
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed is absorbed and restarts the repeat delay.
        if (syncPressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= press_d | repeat_d;
    end
  end

  assign bus.button_level  = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.step_pulse    = step_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table, exact-edge sequences and random stimulus.
// Instance A (active-high) is shadowed every cycle by a run-length/timestamp reference model.
module tb_button_debouncer;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;

  always #5 clk = ~clk;

  button_debouncer_if ifA ();
  button_debouncer_if ifB ();

  button_debouncer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR), .ACTIVE_LOW(0)
  ) dutA (
    .clk   (clk),
    .reset (rstA),
    .bus   (ifA)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR), .ACTIVE_LOW(1)
  ) dutB (
    .clk   (clk),
    .reset (rstB),
    .bus   (ifB)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: what clk sees two edges late, accepted level, run length, next repeat time.
  logic mM0, mM1, mLvl, mPress, mRel, mRep;
  int   mRun, mT, mNextRep;

  typedef struct {
    logic pin;
    int   hold;
    int   expPress;
    int   expRel;
    int   expRep;
    logic expLevel;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      if (failCount <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    logic s;
    if (rstA) begin
      mM0 = 0; mM1 = 0; mLvl = 0; mPress = 0; mRel = 0; mRep = 0;
      mRun = 0; mT = 0; mNextRep = 0;
      return;
    end
    s   = mM1;
    mM1 = mM0;
    mM0 = ifA.button_in;
    mPress = 0; mRel = 0; mRep = 0;
    mT++;
    if (!mLvl) begin
      if (s) begin
        mRun++;
        if (mRun == D + 1) begin
          mPress = 1; mLvl = 1; mRun = 0; mNextRep = mT + RD - D;
        end
      end else begin
        mRun = 0;
      end
    end else if (!s) begin
      mRun++;
      if (mRun == D + 1) begin
        mRel = 1; mLvl = 0; mRun = 0;
      end
    end else if (mRun > 0) begin
      mRun = 0;
      mNextRep = mT + RD - D;
    end else if (mT == mNextRep) begin
      mRep = 1;
      mNextRep = mT + RR;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("A level",   ifA.button_level,  mLvl);
    checkOutput("A press",   ifA.press_pulse,   mPress);
    checkOutput("A release", ifA.release_pulse, mRel);
    checkOutput("A repeat",  ifA.repeat_pulse,  mRep);
    checkOutput("A step",    ifA.step_pulse,    mPress | mRep);
  endtask

  task automatic applyStimulus(input vec_t v, output int nP, output int nR, output int nRep,
                               output logic lvl);
    ifA.button_in = v.pin;
    nP = 0; nR = 0; nRep = 0;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      nP   += int'(ifA.press_pulse);
      nR   += int'(ifA.release_pulse);
      nRep += int'(ifA.repeat_pulse);
    end
    lvl = ifA.button_level;
  endtask

  initial begin
    int   nP, nR, nRep, pressEdge, stepEdge, relEdge, repCount, rep1, rep2, pressCount;
    logic lvl, lvl6, lvl7;

    // Bounce rejection, bouncy press, release bounce; counts are per segment.
    vecs[0]  = '{1'b1, 2,  0, 0, 0, 1'b0};
    vecs[1]  = '{1'b0, 2,  0, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, 2,  0, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 2,  0, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 10, 0, 0, 0, 1'b0};
    vecs[5]  = '{1'b1, 3,  0, 0, 0, 1'b0};
    vecs[6]  = '{1'b0, 1,  0, 0, 0, 1'b0};
    vecs[7]  = '{1'b1, 3,  0, 0, 0, 1'b0};
    vecs[8]  = '{1'b0, 1,  0, 0, 0, 1'b0};
    vecs[9]  = '{1'b1, 3,  0, 0, 0, 1'b0};
    vecs[10] = '{1'b0, 1,  0, 0, 0, 1'b0};
    vecs[11] = '{1'b1, 12, 1, 0, 0, 1'b1};
    vecs[12] = '{1'b0, 12, 0, 1, 0, 1'b0};
    vecs[13] = '{1'b0, 4,  0, 0, 0, 1'b0};
    vecs[14] = '{1'b1, 10, 1, 0, 0, 1'b1};
    vecs[15] = '{1'b0, 2,  0, 0, 0, 1'b1};
    vecs[16] = '{1'b1, 18, 0, 0, 0, 1'b1};
    vecs[17] = '{1'b1, 2,  0, 0, 1, 1'b1};
    vecs[18] = '{1'b0, 12, 0, 1, 0, 1'b0};

    ifA.button_in = 1'b0;
    ifB.button_in = 1'b1;
    rstA = 1'b1;
    rstB = 1'b1;
    modelStep();
    repeat (3) tick();
    checkOutput("B reset outputs",
                {ifB.button_level, ifB.press_pulse, ifB.release_pulse, ifB.repeat_pulse, ifB.step_pulse}, 0);
    rstA = 1'b0;
    rstB = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i], nP, nR, nRep, lvl);
      checkOutput($sformatf("vec%0d press count", i),   nP,   vecs[i].expPress);
      checkOutput($sformatf("vec%0d release count", i), nR,   vecs[i].expRel);
      checkOutput($sformatf("vec%0d repeat count", i),  nRep, vecs[i].expRep);
      checkOutput($sformatf("vec%0d level", i),         lvl,  vecs[i].expLevel);
    end

    // Clean press: exact edges for press, level and repeats.
    ifA.button_in = 1'b1;
    pressEdge = -1; stepEdge = -1; rep1 = -1; rep2 = -1; repCount = 0; lvl6 = 1'bx; lvl7 = 1'bx;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (ifA.press_pulse && pressEdge < 0) pressEdge = e;
      if (ifA.step_pulse && stepEdge < 0) stepEdge = e;
      if (ifA.repeat_pulse) begin
        repCount++;
        if (rep1 < 0) rep1 = e;
        else if (rep2 < 0) rep2 = e;
      end
      if (e == 6) lvl6 = ifA.button_level;
      if (e == 7) lvl7 = ifA.button_level;
    end
    checkOutput("clean press edge", pressEdge, 7);
    checkOutput("clean step edge", stepEdge, 7);
    checkOutput("level before edge 7", lvl6, 0);
    checkOutput("level at edge 7", lvl7, 1);
    checkOutput("first repeat edge", rep1, 23);
    checkOutput("second repeat edge", rep2, 31);
    checkOutput("repeat count in 40", repCount, 3);

    ifA.button_in = 1'b0;
    relEdge = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (ifA.release_pulse && relEdge < 0) relEdge = e;
      if (e == 6) lvl6 = ifA.button_level;
    end
    checkOutput("release edge", relEdge, 7);
    checkOutput("level before release", lvl6, 1);
    checkOutput("level after release", ifA.button_level, 0);

    // Active-low instance, reset while held, then re-press after reset release.
    ifB.button_in = 1'b0;
    pressEdge = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (ifB.press_pulse && pressEdge < 0) pressEdge = e;
    end
    checkOutput("B press edge", pressEdge, 7);
    checkOutput("B level held", ifB.button_level, 1);
    rstB = 1'b1;
    #1;
    checkOutput("B async reset outputs",
                {ifB.button_level, ifB.press_pulse, ifB.release_pulse, ifB.repeat_pulse, ifB.step_pulse}, 0);
    for (int e = 0; e < 3; e++) begin
      tick();
      checkOutput("B held reset outputs",
                  {ifB.button_level, ifB.press_pulse, ifB.release_pulse, ifB.repeat_pulse, ifB.step_pulse}, 0);
    end
    rstB = 1'b0;
    pressEdge = -1; pressCount = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (ifB.press_pulse) begin
        pressCount++;
        if (pressEdge < 0) pressEdge = e;
      end
    end
    checkOutput("B press after reset edge", pressEdge, 7);
    checkOutput("B press after reset count", pressCount, 1);
    ifB.button_in = 1'b1;

    // Random segments, with occasional reset, checked every cycle by the model.
    for (int s = 0; s < 80; s++) begin
      ifA.button_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        rstA = 1'b1;
        repeat (2) tick();
        rstA = 1'b0;
      end
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw push-button input from the board before the hex display counter uses it.
- Synchronises the asynchronous pin into clk and rejects contact bounce with a stability counter.
- Emits one-cycle press, release and auto-repeat strobes; step_pulse drives the display counter's increment input.
- Sits directly upstream of the hex display counter, one instance per button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2.
- REPEAT_DELAY_CYCLES, 50000000, cycles held after the accepted press before the first repeat_pulse; legal range > DEBOUNCE_CYCLES.
- REPEAT_RATE_CYCLES, 10000000, cycles between successive repeat_pulse while held; legal range >= 2.
- ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; the pin is inverted before synchronisation.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- button_in  input  1  raw button pin, asynchronous to clk
- button_level  output  1  debounced level, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- repeat_pulse  output  1  one-cycle strobe per auto-repeat tick
- step_pulse  output  1  press_pulse OR repeat_pulse, registered

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All flops reset asynchronously.
- Reset values:
  - All outputs 0; FSM in IDLE; counter 0.
  - Synchroniser flops reset to the not-pressed value.
- Synchroniser: 2-flop on the polarity-corrected pin. The FSM sees only the second flop, s1.
- Counter: single shared counter, width $clog2 of the maximum of the three cycle parameters.
- FSM states: IDLE, PRESS_WAIT, PRESSED, REPEAT, RELEASE_WAIT.
- IDLE:
  - s1 = 1 -> PRESS_WAIT, cnt <= 0.
- PRESS_WAIT:
  - s1 = 0 -> IDLE with no pulse (bounce rejected).
  - Otherwise, if cnt = DEBOUNCE_CYCLES-1 -> PRESSED, press_pulse = 1, button_level <= 1, cnt <= 0.
  - Otherwise cnt++.
- PRESSED:
  - s1 = 0 -> RELEASE_WAIT, cnt <= 0.
  - Otherwise, if cnt = REPEAT_DELAY_CYCLES-DEBOUNCE_CYCLES-1 -> REPEAT, repeat_pulse = 1, cnt <= 0.
  - Otherwise cnt++.
- REPEAT:
  - s1 = 0 -> RELEASE_WAIT, cnt <= 0.
  - Otherwise, if cnt = REPEAT_RATE_CYCLES-1 -> stay in REPEAT, repeat_pulse = 1, cnt <= 0.
  - Otherwise cnt++.
- RELEASE_WAIT:
  - s1 = 1 -> PRESSED, cnt <= 0, no pulse. The release bounce is absorbed, button_level stays 1 and the repeat delay restarts.
  - Otherwise, if cnt = DEBOUNCE_CYCLES-1 -> IDLE, release_pulse = 1, button_level <= 0.
  - Otherwise cnt++.
- Pulse registration: all pulses are registered and high for exactly one cycle; step_pulse is registered alongside them.
- Press latency: counting the first clk edge that samples button_in pressed as edge 1, press_pulse and step_pulse are high after edge DEBOUNCE_CYCLES+3, given the pin stays stable.
- Release latency: release_pulse follows the same DEBOUNCE_CYCLES+3 latency from the first stable not-pressed sample.
- First repeat: press_pulse and the first repeat_pulse are exactly REPEAT_DELAY_CYCLES-DEBOUNCE_CYCLES cycles apart.
- Subsequent repeats: successive repeat_pulse strobes are exactly REPEAT_RATE_CYCLES cycles apart.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse in either direction.
- Pulse exclusivity: press_pulse, repeat_pulse and release_pulse are never high in the same cycle.
- Reset mid-press: returns to IDLE with all outputs 0.
  - A button still held at reset release is treated as a new press after the full debounce, so one press_pulse is emitted.
- Counter wrap: the counter never wraps. Every compare resets it to 0 before it can exceed its terminal count.
- Illegal state encoding: returns to IDLE on the next clk edge, with all outputs 0.

Decomposition:
- Shared package/header button_pkg.vh holds:
  - the FSM state localparams (3-bit encoding);
  - the default cycle constants for 100 MHz.
- Sub-module sync_2ff:
  - 1-bit, 2-flop synchroniser with RESET_VAL parameter;
  - reused for the reset and switch inputs elsewhere.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, ACTIVE_LOW=0, unless a scenario states otherwise.
- Clean press: button_in 0->1 held 40 cycles, then released -> press_pulse and step_pulse high after edge 7; button_level 1 from edge 7; repeat_pulse at edges 23 and 31.
  - Release: button_level falls and release_pulse fires on edge 7 counted from the first 0 sample.
- Bounce rejection: button_in toggles 1,0,1,0 at 2-cycle intervals, then stays 0 -> no pulses; button_level stays 0.
- Bouncy press: 3-cycle bursts of 1 separated by single 0s, then stable 1 -> exactly one press_pulse, 7 edges after the final stable-1 sample begins.
- Release bounce: while held, drop to 0 for 2 cycles, then back to 1 -> no release_pulse; button_level stays 1; next repeat_pulse exactly 16 cycles after re-entering PRESSED.
- Active-low and reset: ACTIVE_LOW=1, pin held 0, reset asserted after press_pulse -> all outputs 0 while reset is high.
  - After reset falls with the pin still 0, one press_pulse fires 7 edges later.
